// File: rtl/jk_pkg.sv
// Shared JK flip-flop mode encoding and drive helper for the counter slice.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_t;

    // Returns {j, k} for the requested cell behaviour.
    function automatic logic [1:0] jk_drive(input jk_mode_t mode);
        return 2'(mode);
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   out <= 1'b0;
                2'b10:   out <= 1'b1;
                2'b11:   out <= ~out;
                default: out <= out;
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MOD up/down counter whose state bits live in JK cells; this module
// only decodes per-bit J/K drive for hold, count, load and wrap.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             at_max;
    logic             at_zero;
    logic             over;
    logic             wrap_c;
    logic             do_wrap;
    logic             wrapped_q;
    logic             wrapped_d;

    assign at_max  = (count_q == MAX_V);
    assign at_zero = (count_q == '0);
    // Only reachable from a corrupted state when MOD is not a power of two.
    assign over    = (count_q > MAX_V);

    assign wrap_c  = up ? (at_max | over) : (at_zero | over);
    assign do_wrap = ~load & en & wrap_c;

    // Load saturates at MOD-1; a wrap lands on 0 (up) or MOD-1 (down).
    assign target  = load ? ((d > MAX_V) ? MAX_V : d)
                          : (up ? '0 : MAX_V);

    assign tc        = en & ~load & ((up & at_max) | (~up & at_zero));
    assign wrapped_d = do_wrap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_mode_t mode_d;

        if (i == 0) begin : g_t0
            assign t_up[i] = 1'b1;
            assign t_dn[i] = 1'b1;
        end else begin : g_tn
            assign t_up[i] = &count_q[i-1:0];
            assign t_dn[i] = &(~count_q[i-1:0]);
        end

        always_comb begin
            mode_d = JK_HOLD;
            if (load || do_wrap) begin
                mode_d = target[i] ? JK_SET : JK_RESET;
            end else if (en) begin
                mode_d = (up ? t_up[i] : t_dn[i]) ? JK_TOGGLE : JK_HOLD;
            end
        end

        assign {j_d[i], k_d[i]} = jk_drive(mode_d);

        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_d[i]),
            .k     (k_d[i]),
            .out   (count_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed-vector bench for jk_sync_counter with a queued scoreboard and a
// negedge monitor; also checks a two-digit decimal cascade.
module tb_jk_sync_counter;

    typedef struct packed {
        logic       cas;
        logic [7:0] cnt;
        logic       tc;
        logic       wr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] count;
    logic       tc;
    logic       wrapped;

    logic       c_en;
    logic [3:0] lo_count;
    logic       lo_tc;
    logic       lo_wrapped;
    logic [3:0] hi_count;
    logic       hi_tc;
    logic       hi_wrapped;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_errors;

    jk_sync_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up      (up),
        .load    (load),
        .d       (d),
        .count   (count),
        .tc      (tc),
        .wrapped (wrapped)
    );

    jk_sync_counter #(.WIDTH(4), .MOD(10)) u_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (c_en),
        .up      (1'b1),
        .load    (1'b0),
        .d       (4'd0),
        .count   (lo_count),
        .tc      (lo_tc),
        .wrapped (lo_wrapped)
    );

    jk_sync_counter #(.WIDTH(4), .MOD(10)) u_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (lo_tc),
        .up      (1'b1),
        .load    (1'b0),
        .d       (4'd0),
        .count   (hi_count),
        .tc      (hi_tc),
        .wrapped (hi_wrapped)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle; the expectation describes the state seen with these inputs.
    task automatic cyc(input logic l, input logic e, input logic u, input logic [3:0] dv,
                       input int ec, input logic etc, input logic ew);
        exp_t x;
        load = l;
        en   = e;
        up   = u;
        d    = dv;
        x.cas = 1'b0;
        x.cnt = 8'(ec);
        x.tc  = etc;
        x.wr  = ew;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cas) begin
                chk("cas_count", int'({hi_count, lo_count}), int'(mon_e.cnt));
                chk("cas_tc", int'(hi_tc), int'(mon_e.tc));
                chk("cas_wrapped", int'(hi_wrapped), int'(mon_e.wr));
            end else begin
                chk("count", int'(count), int'(mon_e.cnt));
                chk("tc", int'(tc), int'(mon_e.tc));
                chk("wrapped", int'(wrapped), int'(mon_e.wr));
            end
        end
    end

    initial begin
        exp_t x;
        int   v;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        up    = 1'b0;
        load  = 1'b0;
        d     = 4'd0;
        c_en  = 1'b0;

        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_wrapped", int'(wrapped), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle from count=7
        cyc(1'b1, 1'b0, 1'b0, 4'd7, 0, 1'b0, 1'b0);
        load = 1'b0;
        chk("pre_rst_count", int'(count), 7);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_wrapped", int'(wrapped), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hold
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b0);

        // Up wrap from 8
        cyc(1'b1, 1'b1, 1'b1, 4'd8, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 8, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 9, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 1, 1'b0, 1'b0);

        // Down wrap from 1
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 9, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 8, 1'b0, 1'b0);

        // Load priority and saturation
        cyc(1'b1, 1'b1, 1'b1, 4'd4, 8, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd13, 4, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd9, 9, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 9, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd5, 9, 1'b0, 1'b0);

        // Direction flip around 5
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 6, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 6, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 5, 1'b0, 1'b0);

        // Reset drops a pending wrapped pulse
        cyc(1'b1, 1'b0, 1'b0, 4'd9, 5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 9, 1'b1, 1'b0);
        en = 1'b0;
        chk("pend_wrapped", int'(wrapped), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("pend_rst_wrapped", int'(wrapped), 0);
        chk("pend_rst_count", int'(count), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-digit cascade: 00..99 then back to 00
        c_en = 1'b1;
        for (int i = 0; i <= 101; i++) begin
            v     = i % 100;
            x.cas = 1'b1;
            x.cnt = {4'(v / 10), 4'(v % 10)};
            x.tc  = (v == 99);
            x.wr  = (i == 100);
            exp_q.push_back(x);
            @(posedge clk);
            #1;
        end
        c_en = 1'b0;

        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
